// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Holds widths, forwarding select codes, the shadow stage bundle and the forward-select helper.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rs1_used;
        logic              rs2_used;
        logic              reg_write;
        logic              mem_read;
    } stage_t;

    // A load in MEM has no data yet; the load-use stall makes WB the source.
    function automatic logic [1:0] fwd_sel(
        input stage_t            mem,
        input stage_t            wb,
        input logic [REG_AW-1:0] rs,
        input logic              used
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && mem.reg_write && !mem.mem_read &&
            mem.rd != '0 && mem.rd == rs)
            sel = FWD_MEM;
        else if (used && wb.reg_write &&
                 wb.rd != '0 && wb.rd == rs)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives ID fields, branch, freeze); slave: controller.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic              freeze;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_branch_taken;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              pipe_en;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output freeze, id_valid, id_rs1, id_rs2,
        output id_rs1_used, id_rs2_used, id_rd,
        output id_reg_write, id_mem_read, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush,
        input  idex_bubble, pipe_en, fwd_a, fwd_b,
        input  stall_count, flush_count
    );

    modport slave (
        input  freeze, id_valid, id_rs1, id_rs2,
        input  id_rs1_used, id_rs2_used, id_rd,
        input  id_reg_write, id_mem_read, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush,
        output idex_bubble, pipe_en, fwd_a, fwd_b,
        output stall_count, flush_count
    );

endinterface

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage register: clear-on-load, load, or hold.
// Ports: clock, reset, clr_i, load_i, d_i (stage_t), q_o (stage_t).
module hazard_stage_reg
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   clr_i,
    input  logic   load_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t st_q, st_d;

    always_comb begin
        st_d = st_q;
        if (load_i)
            st_d = clr_i ? '0 : d_i;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            st_q <= '0;
        else
            st_q <= st_d;
    end

    assign q_o = st_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: stalls, flushes, bubbles, EX forward selects, event counters.
// Ports: clock, reset, hz (slave modport of pipeline_hazard_ctrl_if).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    stage_t id_s, ex_s, mem_s, wb_s;
    logic   load_use;
    logic   stall_ev, flush_ev;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Qualify control bits with valid so an empty ID slot never hazards.
    always_comb begin
        id_s           = '0;
        id_s.valid     = hz.id_valid;
        id_s.rd        = hz.id_rd;
        id_s.rs1       = hz.id_rs1;
        id_s.rs2       = hz.id_rs2;
        id_s.rs1_used  = hz.id_valid & hz.id_rs1_used;
        id_s.rs2_used  = hz.id_valid & hz.id_rs2_used;
        id_s.reg_write = hz.id_valid & hz.id_reg_write;
        id_s.mem_read  = hz.id_valid & hz.id_mem_read;
    end

    assign load_use = hz.id_valid && ex_s.mem_read && ex_s.rd != '0 &&
        ((hz.id_rs1_used && hz.id_rs1 == ex_s.rd) ||
         (hz.id_rs2_used && hz.id_rs2 == ex_s.rd));

    // Freeze beats branch, branch beats stall (stalled insn is wrong-path).
    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.pipe_en     = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        stall_ev       = 1'b0;
        flush_ev       = 1'b0;
        if (hz.freeze) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.pipe_en    = 1'b0;
        end else if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
            flush_ev       = 1'b1;
        end else if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
            stall_ev       = 1'b1;
        end
    end

    hazard_stage_reg u_ex (
        .clock (clock), .reset (reset),
        .clr_i (hz.idex_bubble), .load_i (hz.pipe_en),
        .d_i   (id_s), .q_o (ex_s)
    );

    hazard_stage_reg u_mem (
        .clock (clock), .reset (reset),
        .clr_i (1'b0), .load_i (hz.pipe_en),
        .d_i   (ex_s), .q_o (mem_s)
    );

    hazard_stage_reg u_wb (
        .clock (clock), .reset (reset),
        .clr_i (1'b0), .load_i (hz.pipe_en),
        .d_i   (mem_s), .q_o (wb_s)
    );

    assign hz.fwd_a = fwd_sel(mem_s, wb_s, ex_s.rs1, ex_s.rs1_used);
    assign hz.fwd_b = fwd_sel(mem_s, wb_s, ex_s.rs2, ex_s.rs2_used);

    // Saturating event counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_ev && stall_q != '1)
            stall_d = stall_q + CNT_W'(1);
        if (flush_ev && flush_q != '1)
            flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hz.stall_count = stall_q;
    assign hz.flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expectation queue.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    typedef enum int {
        O_PC, O_IFID, O_FL, O_BUB, O_PE, O_FA, O_FB, O_SC, O_FC
    } obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   total  = 0;
    int   bad    = 0;
    int   exp_sc = 0;
    int   exp_fc = 0;

    function automatic logic [31:0] observe(obs_e s);
        logic [31:0] o;
        o = '0;
        case (s)
            O_PC:   o = 32'(hz.pc_write);
            O_IFID: o = 32'(hz.ifid_write);
            O_FL:   o = 32'(hz.ifid_flush);
            O_BUB:  o = 32'(hz.idex_bubble);
            O_PE:   o = 32'(hz.pipe_en);
            O_FA:   o = 32'(hz.fwd_a);
            O_FB:   o = 32'(hz.fwd_b);
            O_SC:   o = 32'(hz.stall_count);
            O_FC:   o = 32'(hz.flush_count);
            default: o = 'x;
        endcase
        return o;
    endfunction

    task automatic expect_v(string tag, obs_e s, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic expect_ctl(string tag, logic pc, logic ifw,
                              logic fl, logic bub, logic pe);
        expect_v({tag, ".pc_write"}, O_PC, 32'(pc));
        expect_v({tag, ".ifid_write"}, O_IFID, 32'(ifw));
        expect_v({tag, ".ifid_flush"}, O_FL, 32'(fl));
        expect_v({tag, ".idex_bubble"}, O_BUB, 32'(bub));
        expect_v({tag, ".pipe_en"}, O_PE, 32'(pe));
    endtask

    task automatic expect_cnt(string tag);
        expect_v({tag, ".stall_count"}, O_SC, 32'(exp_sc));
        expect_v({tag, ".flush_count"}, O_FC, 32'(exp_fc));
    endtask

    task automatic expect_fwd(string tag, logic [1:0] a, logic [1:0] b);
        expect_v({tag, ".fwd_a"}, O_FA, 32'(a));
        expect_v({tag, ".fwd_b"}, O_FB, 32'(b));
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = observe(e.sel);
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic set_id(logic v, logic [4:0] rs1, logic [4:0] rs2,
                          logic u1, logic u2, logic [4:0] rd,
                          logic rw, logic mr);
        hz.id_valid     = v;
        hz.id_rs1       = rs1;
        hz.id_rs2       = rs2;
        hz.id_rs1_used  = u1;
        hz.id_rs2_used  = u2;
        hz.id_rd        = rd;
        hz.id_reg_write = rw;
        hz.id_mem_read  = mr;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic next();
        @(negedge clock);
    endtask

    task automatic drain();
        nop();
        hz.freeze          = 1'b0;
        hz.ex_branch_taken = 1'b0;
        repeat (3) next();
    endtask

    initial begin
        reset              = 1'b1;
        hz.freeze          = 1'b0;
        hz.ex_branch_taken = 1'b0;
        nop();

        // reset values
        settle();
        expect_ctl("rst", 1, 1, 0, 0, 1);
        expect_fwd("rst", 2'b00, 2'b00);
        expect_cnt("rst");
        check_all();
        next();
        reset = 1'b0;

        // load-use: lw x5 then add x6,x5,x7
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        settle();
        expect_ctl("lu.lw", 1, 1, 0, 0, 1);
        check_all();
        next();
        set_id(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0);
        settle();
        expect_ctl("lu.stall", 0, 0, 0, 1, 1);
        check_all();
        next();
        exp_sc++;
        settle();
        expect_ctl("lu.after", 1, 1, 0, 0, 1);
        expect_cnt("lu.after");
        expect_fwd("lu.bubble", 2'b00, 2'b00);
        check_all();
        next();
        nop();
        settle();
        expect_fwd("lu.ex", 2'b01, 2'b00);
        check_all();
        drain();

        // back-to-back ALU dependency
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        next();
        set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        settle();
        expect_ctl("b2b.id", 1, 1, 0, 0, 1);
        check_all();
        next();
        nop();
        settle();
        expect_fwd("b2b.mem", 2'b10, 2'b10);
        check_all();
        drain();

        // one NOP between producer and consumer
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        next();
        nop();
        next();
        set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        next();
        nop();
        settle();
        expect_fwd("gap.wb", 2'b01, 2'b01);
        check_all();
        drain();

        // MEM wins over WB for the same register
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        next();
        set_id(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0);
        next();
        set_id(1, 5'd5, 5'd9, 1, 1, 5'd6, 1, 0);
        next();
        nop();
        settle();
        expect_fwd("prio", 2'b10, 2'b00);
        check_all();
        drain();

        // load-use together with a taken branch
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
        next();
        set_id(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0);
        hz.ex_branch_taken = 1'b1;
        settle();
        expect_ctl("br.lu", 1, 1, 1, 1, 1);
        check_all();
        next();
        exp_fc++;
        hz.ex_branch_taken = 1'b0;
        nop();
        settle();
        expect_cnt("br.after");
        expect_ctl("br.after", 1, 1, 0, 0, 1);
        check_all();
        drain();

        // freeze over a pending load-use
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1);
        next();
        set_id(1, 5'd3, 5'd9, 1, 1, 5'd10, 1, 0);
        hz.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            expect_ctl("frz.hold", 0, 0, 0, 0, 0);
            expect_cnt("frz.hold");
            check_all();
            next();
        end
        hz.freeze = 1'b0;
        settle();
        expect_ctl("frz.rel", 0, 0, 0, 1, 1);
        check_all();
        next();
        exp_sc++;
        settle();
        expect_ctl("frz.post", 1, 1, 0, 0, 1);
        expect_cnt("frz.post");
        check_all();
        drain();

        // freeze masks a branch until it drops
        hz.freeze          = 1'b1;
        hz.ex_branch_taken = 1'b1;
        settle();
        expect_ctl("frzbr", 0, 0, 0, 0, 0);
        check_all();
        next();
        hz.freeze = 1'b0;
        settle();
        expect_cnt("frzbr.hold");
        expect_ctl("frzbr.rel", 1, 1, 1, 1, 1);
        check_all();
        next();
        exp_fc++;
        hz.ex_branch_taken = 1'b0;
        settle();
        expect_cnt("frzbr.post");
        check_all();
        drain();

        // x0 never forwards, never stalls
        set_id(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);
        next();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0);
        next();
        nop();
        settle();
        expect_fwd("x0.fwd", 2'b00, 2'b00);
        check_all();
        drain();
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        next();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0);
        settle();
        expect_ctl("x0.lu", 1, 1, 0, 0, 1);
        check_all();
        next();
        settle();
        expect_cnt("x0.cnt");
        check_all();
        drain();

        // run stall count to 5, then reset mid-stall
        while (exp_sc < 5) begin
            set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
            next();
            set_id(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0);
            next();
            exp_sc++;
            nop();
            next();
        end
        settle();
        expect_cnt("pre.rst");
        check_all();
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        next();
        set_id(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0);
        settle();
        expect_ctl("mid.stall", 0, 0, 0, 1, 1);
        check_all();
        reset = 1'b1;
        exp_sc = 0;
        exp_fc = 0;
        #1;
        expect_ctl("rst.mid", 1, 1, 0, 0, 1);
        expect_cnt("rst.mid");
        expect_fwd("rst.mid", 2'b00, 2'b00);
        check_all();
        next();
        reset = 1'b0;
        nop();
        settle();
        expect_cnt("rst.post");
        expect_ctl("rst.post", 1, 1, 0, 0, 1);
        check_all();
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
